// File: rtl/priority_arbiter_4_pkg.sv
// Shared definitions for the 4-requester arbiter: FSM encodings and widths.
// Pure declarations, no logic, no latency, no flow control.
package priority_arbiter_4_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam int NUM_REQ = 4;
    localparam int HOLD_W  = 8;

endpackage

// File: rtl/priority_arbiter_4_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
// Wires only; the req/gnt level handshake is the sole backpressure.
interface priority_arbiter_4_if;
    import priority_arbiter_4_pkg::*;

    logic               enable;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [1:0]         gnt_id;
    logic               gnt_valid;
    logic               timeout;

    modport master (
        output enable, req,
        input  gnt, gnt_id, gnt_valid, timeout
    );

    modport slave (
        input  enable, req,
        output gnt, gnt_id, gnt_valid, timeout
    );

endinterface

// File: rtl/priority_arbiter_4_pick.sv
// Combinational rotating-priority pick: search order base-1, base-2, ..., base (mod 4).
// Zero latency; no flow control. base=0 gives plain fixed priority 3>2>1>0.
module arb_pick_4
    import priority_arbiter_4_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         base,
    output logic [1:0]         winner,
    output logic               any
);

    logic [NUM_REQ-1:0] rot;
    logic [1:0]         idx;
    logic [1:0]         sel;

    // Rotate so position 3 holds the highest-ranked requester, then take the top set bit.
    always_comb begin
        rot = '0;
        idx = 2'd0;
        sel = 2'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx    = 2'(i) + base;
            rot[i] = req[idx];
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rot[i]) sel = 2'(i);
        end
        winner = sel + base;
        any    = |req;
    end

endmodule

// File: rtl/priority_arbiter_4.sv
// 4-way arbiter: 1-cycle req->gnt, grant held until release or MAX_HOLD, then one turnaround cycle.
// No pre-emption; enable=0 blocks and releases. Define ROUND_ROBIN_EN for rotating priority.
module priority_arbiter_4
    import priority_arbiter_4_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    priority_arbiter_4_if.slave  bus
);

`ifdef ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t              state;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [1:0]          last_id;
    logic [1:0]          base;
    logic [1:0]          win;
    logic                any;

    // Fixed-priority build still tracks last_id but masks it out of the pick.
    assign base = RR_EN ? last_id : 2'd0;

    arb_pick_4 u_pick (
        .req    (bus.req),
        .base   (base),
        .winner (win),
        .any    (any)
    );

    assign bus.gnt_valid = |bus.gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            bus.gnt     <= '0;
            bus.gnt_id  <= 2'd0;
            bus.timeout <= 1'b0;
            hold_cnt    <= '0;
            last_id     <= 2'd0;
        end else begin
            bus.timeout <= 1'b0;
            case (state)
                ST_IDLE, ST_RELEASE: begin
                    if (bus.enable && any) begin
                        state      <= ST_GRANT;
                        bus.gnt    <= NUM_REQ'(1) << win;
                        bus.gnt_id <= win;
                        hold_cnt   <= '0;
                    end else begin
                        state   <= ST_IDLE;
                        bus.gnt <= '0;
                    end
                end
                ST_GRANT: begin
                    if (!bus.enable || !bus.req[bus.gnt_id]) begin
                        state   <= ST_RELEASE;
                        bus.gnt <= '0;
                        last_id <= bus.gnt_id;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state       <= ST_RELEASE;
                        bus.gnt     <= '0;
                        last_id     <= bus.gnt_id;
                        bus.timeout <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    bus.gnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_priority_arbiter_4.sv
// Randomized and directed bench for priority_arbiter_4 against an ownership-level reference model.
module tb_priority_arbiter_4;

    localparam int MH = 4;
`ifdef ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    priority_arbiter_4_if bus ();

    priority_arbiter_4 #(.MAX_HOLD(MH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: who owns the resource and for how many cycles so far.
    int m_owner = -1;
    int m_held  = 0;
    int m_last  = 0;
    bit m_to    = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_pick(input logic [3:0] r, input int last);
        int b;
        b = RR ? last : 0;
        for (int k = 1; k <= 4; k++) begin
            if (r[(b - k + 8) % 4]) return (b - k + 8) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_last  = 0;
        m_to    = 1'b0;
    endtask

    task automatic model_edge(input bit en, input logic [3:0] r);
        m_to = 1'b0;
        if (m_owner >= 0) begin
            if (!en || !r[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
            end else if (m_held == MH) begin
                m_to    = 1'b1;
                m_last  = m_owner;
                m_owner = -1;
            end else begin
                m_held++;
            end
        end else if (en && r != 4'd0) begin
            m_owner = model_pick(r, m_last);
            m_held  = 1;
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [3:0] eg;
        eg = (m_owner >= 0) ? (4'd1 << m_owner) : 4'd0;
        check_eq({tag, ".gnt"},       32'(bus.gnt),       32'(eg));
        check_eq({tag, ".gnt_valid"}, 32'(bus.gnt_valid), 32'(m_owner >= 0));
        check_eq({tag, ".timeout"},   32'(bus.timeout),   32'(m_to));
        if (m_owner >= 0)
            check_eq({tag, ".gnt_id"}, 32'(bus.gnt_id), 32'(m_owner));
    endtask

    task automatic step(input string tag, input bit en, input logic [3:0] r);
        @(negedge clk);
        bus.enable = en;
        bus.req    = r;
        @(posedge clk);
        model_edge(en, r);
        #1;
        check_outputs(tag);
    endtask

    logic [3:0] rr;
    bit         re;

    initial begin
        rst_n      = 1'b0;
        bus.enable = 1'b0;
        bus.req    = 4'd0;
        model_reset();
        #12;
        check_eq("reset.gnt",       32'(bus.gnt),       32'd0);
        check_eq("reset.gnt_id",    32'(bus.gnt_id),    32'd0);
        check_eq("reset.gnt_valid", 32'(bus.gnt_valid), 32'd0);
        check_eq("reset.timeout",   32'(bus.timeout),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Highest index wins, then owner release and turnaround.
        step("prio", 1'b1, 4'b1010);
        check_eq("prio.gnt_const", 32'(bus.gnt), 32'h8);
        check_eq("prio.id_const",  32'(bus.gnt_id), 32'd3);
        step("prio_gap", 1'b1, 4'b0010);
        check_eq("prio_gap.const", 32'(bus.gnt), 32'h0);
        step("prio_next", 1'b1, 4'b0010);
        check_eq("prio_next.const", 32'(bus.gnt), 32'h2);
        step("prio_drop", 1'b1, 4'b0000);
        step("idle", 1'b1, 4'b0000);

        // Hold limit on a lone requester.
        repeat (12) step("hold", 1'b1, 4'b0001);
        step("hold_drop", 1'b1, 4'b0000);

        // Enable low releases and blocks.
        step("en_grant", 1'b1, 4'b0100);
        step("en_off", 1'b0, 4'b0100);
        check_eq("en_off.const", 32'(bus.gnt), 32'h0);
        repeat (3) step("en_block", 1'b0, 4'b1111);
        step("en_on", 1'b1, 4'b1111);
        step("en_clr", 1'b0, 4'b0000);
        step("en_clr2", 1'b0, 4'b0000);

        // Owner drops while another raises: one gap cycle.
        step("swap_grant", 1'b1, 4'b0001);
        step("swap_gap", 1'b1, 4'b0010);
        check_eq("swap_gap.const", 32'(bus.gnt), 32'h0);
        step("swap_new", 1'b1, 4'b0010);
        check_eq("swap_new.const", 32'(bus.gnt), 32'h2);

        // Everyone requesting continuously.
        step("all_clr", 1'b0, 4'b0000);
        repeat (24) step("all", 1'b1, 4'b1111);

        // Asynchronous reset in the middle of a grant.
        step("arst_pre", 1'b0, 4'b0000);
        step("arst_grant", 1'b1, 4'b0100);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst.gnt",       32'(bus.gnt),       32'd0);
        check_eq("arst.gnt_valid", 32'(bus.gnt_valid), 32'd0);
        check_eq("arst.timeout",   32'(bus.timeout),   32'd0);
        model_reset();
        bus.enable = 1'b0;
        bus.req    = 4'd0;
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic with sticky requests and occasional enable drops.
        rr = 4'd0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) rr = 4'($urandom_range(0, 15));
            re = ($urandom_range(0, 9) != 0);
            step("rand", re, rr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
